// File: rtl/hex_pe_cluster_array_if.sv
// Stream bundle for the hex PE cluster array: broadcast IFM, per-engine weights,
// window framing and requantisation controls in; requantised OFM vector out.
interface hex_pe_cluster_array_if #(
  parameter int NUM_PE  = 4,
  parameter int LANES   = 16,
  parameter int DATA_W  = 8,
  parameter int SHIFT_W = 5
) ();
  logic [LANES*DATA_W-1:0]        ifm;
  logic [NUM_PE*LANES*DATA_W-1:0] weight;
  logic                           in_valid;
  logic                           in_ready;
  logic                           in_last;
  logic [NUM_PE-1:0]              pe_enable;
  logic [SHIFT_W-1:0]             shift;
  logic                           relu_en;
  logic [NUM_PE*DATA_W-1:0]       ofm;
  logic                           ofm_valid;
  logic                           ofm_ready;
  logic [NUM_PE-1:0]              ofm_mask;
  logic                           busy;

  modport master (
    output ifm, weight, in_valid, in_last, pe_enable, shift, relu_en, ofm_ready,
    input  in_ready, ofm, ofm_valid, ofm_mask, busy
  );

  modport slave (
    input  ifm, weight, in_valid, in_last, pe_enable, shift, relu_en, ofm_ready,
    output in_ready, ofm, ofm_valid, ofm_mask, busy
  );
endinterface

// File: rtl/hex_pe_cluster_array.sv
// NUM_PE int8 dot-product engines sharing a broadcast IFM; each accumulates a
// multi-beat window, then requantises (round, shift, optional ReLU, clamp) to int8.
module hex_pe_cluster_array #(
  parameter int NUM_PE  = 4,
  parameter int LANES   = 16,
  parameter int DATA_W  = 8,
  parameter int ACC_W   = 32,
  parameter int SHIFT_W = 5
) (
  input  logic                   clk,
  input  logic                   reset_n,
  hex_pe_cluster_array_if.slave  bus
);

  localparam int PROD_W = 2 * DATA_W;
  localparam int SUM_W  = 2 * DATA_W + $clog2(LANES);
  localparam logic signed [ACC_W:0] OFM_MAX = (ACC_W+1)'((1 <<< (DATA_W-1)) - 1);
  localparam logic signed [ACC_W:0] OFM_MIN = (ACC_W+1)'(-(1 <<< (DATA_W-1)));

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCUM  = 2'd1,
    DRAIN  = 2'd2,
    OUTPUT = 2'd3
  } state_e;

  state_e state_q, state_d;

  logic in_ready_s;
  logic ofm_valid_s;
  logic busy_s;
  logic accept_s;
  logic first_s;

  logic signed [PROD_W-1:0] prod_s [NUM_PE][LANES];
  logic signed [SUM_W-1:0]  sum_s  [NUM_PE];

  logic signed [SUM_W-1:0]  sum_q  [NUM_PE];
  logic                     s1_valid_q;
  logic                     s1_first_q;
  logic                     s1_last_q;

  logic signed [ACC_W-1:0]  acc_q  [NUM_PE];
  logic                     acc_last_q;

  logic [NUM_PE-1:0]        cfg_mask_q;
  logic [SHIFT_W-1:0]       cfg_shift_q;
  logic                     cfg_relu_q;

  logic [NUM_PE*DATA_W-1:0] ofm_q;
  logic [NUM_PE-1:0]        ofm_mask_q;

  // Round-half-up, arithmetic shift, optional ReLU, clamp to the int8 range.
  function automatic logic [DATA_W-1:0] requant(
    input logic signed [ACC_W-1:0] acc,
    input logic [SHIFT_W-1:0]      sh,
    input logic                    relu
  );
    logic signed [ACC_W:0] one_v;
    logic signed [ACC_W:0] rnd_v;
    logic signed [ACC_W:0] shd_v;
    int                    amt_v;
    one_v = (ACC_W+1)'(1);
    rnd_v = (ACC_W+1)'(acc);
    amt_v = (int'(sh) > ACC_W - 1) ? ACC_W - 1 : int'(sh);
    if (sh != '0) begin
      rnd_v = rnd_v + (one_v <<< (sh - SHIFT_W'(1)));
    end else begin
      rnd_v = rnd_v;
    end
    shd_v = rnd_v >>> amt_v;
    if (relu && shd_v[ACC_W]) begin
      shd_v = '0;
    end else begin
      shd_v = shd_v;
    end
    if (shd_v > OFM_MAX) begin
      shd_v = OFM_MAX;
    end else if (shd_v < OFM_MIN) begin
      shd_v = OFM_MIN;
    end else begin
      shd_v = shd_v;
    end
    return shd_v[DATA_W-1:0];
  endfunction

  assign accept_s = bus.in_valid && in_ready_s;
  assign first_s  = accept_s && (state_q == IDLE);

  // Window state register.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Window framing: the stream's in_last closes a window, drain waits for the result.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept_s) begin
          state_d = bus.in_last ? DRAIN : ACCUM;
        end else begin
          state_d = IDLE;
        end
      end
      ACCUM: begin
        if (accept_s && bus.in_last) begin
          state_d = DRAIN;
        end else begin
          state_d = ACCUM;
        end
      end
      DRAIN: begin
        if (acc_last_q) begin
          state_d = OUTPUT;
        end else begin
          state_d = DRAIN;
        end
      end
      OUTPUT: begin
        if (bus.ofm_ready) begin
          state_d = IDLE;
        end else begin
          state_d = OUTPUT;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Handshake and status decoded from the state register.
  always_comb begin
    in_ready_s  = 1'b0;
    ofm_valid_s = 1'b0;
    busy_s      = 1'b1;
    case (state_q)
      IDLE: begin
        in_ready_s = 1'b1;
        busy_s     = 1'b0;
      end
      ACCUM:   in_ready_s  = 1'b1;
      DRAIN:   in_ready_s  = 1'b0;
      OUTPUT:  ofm_valid_s = 1'b1;
      default: busy_s      = 1'b1;
    endcase
  end

  // Per-engine signed products and their lane sum.
  always_comb begin
    for (int p = 0; p < NUM_PE; p++) begin
      sum_s[p] = '0;
      for (int i = 0; i < LANES; i++) begin
        prod_s[p][i] = PROD_W'($signed(bus.ifm[i*DATA_W +: DATA_W]))
                     * PROD_W'($signed(bus.weight[(p*LANES+i)*DATA_W +: DATA_W]));
        sum_s[p] = sum_s[p] + SUM_W'(prod_s[p][i]);
      end
    end
  end

  // Window configuration, captured only on the first beat.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cfg_mask_q  <= '0;
      cfg_shift_q <= '0;
      cfg_relu_q  <= 1'b0;
    end else if (first_s) begin
      cfg_mask_q  <= bus.pe_enable;
      cfg_shift_q <= bus.shift;
      cfg_relu_q  <= bus.relu_en;
    end
  end

  // Stage 1: registered lane sums with beat framing flags.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      s1_valid_q <= 1'b0;
      s1_first_q <= 1'b0;
      s1_last_q  <= 1'b0;
      for (int p = 0; p < NUM_PE; p++) sum_q[p] <= '0;
    end else begin
      s1_valid_q <= accept_s;
      s1_first_q <= first_s;
      s1_last_q  <= accept_s && bus.in_last;
      if (accept_s) begin
        for (int p = 0; p < NUM_PE; p++) sum_q[p] <= sum_s[p];
      end
    end
  end

  // Stage 2: accumulators restart on a window's first beat, wrapping otherwise.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      acc_last_q <= 1'b0;
      for (int p = 0; p < NUM_PE; p++) acc_q[p] <= '0;
    end else begin
      acc_last_q <= s1_valid_q && s1_last_q;
      if (s1_valid_q) begin
        for (int p = 0; p < NUM_PE; p++) begin
          acc_q[p] <= s1_first_q ? ACC_W'(sum_q[p]) : acc_q[p] + ACC_W'(sum_q[p]);
        end
      end
    end
  end

  // Stage 3: requantised result, disabled engines forced to zero.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      ofm_q      <= '0;
      ofm_mask_q <= '0;
    end else if (acc_last_q) begin
      ofm_mask_q <= cfg_mask_q;
      for (int p = 0; p < NUM_PE; p++) begin
        ofm_q[p*DATA_W +: DATA_W] <= cfg_mask_q[p]
                                   ? requant(acc_q[p], cfg_shift_q, cfg_relu_q)
                                   : '0;
      end
    end
  end

  assign bus.in_ready  = in_ready_s;
  assign bus.ofm_valid = ofm_valid_s;
  assign bus.busy      = busy_s;
  assign bus.ofm       = ofm_q;
  assign bus.ofm_mask  = ofm_mask_q;

endmodule

// File: tb/tb_hex_pe_cluster_array.sv
// Directed bench for hex_pe_cluster_array: hand-computed results, latency,
// output hold under backpressure and reset discarding a partial window.
module tb_hex_pe_cluster_array;
  localparam int NUM_PE  = 4;
  localparam int LANES   = 16;
  localparam int DATA_W  = 8;
  localparam int ACC_W   = 32;
  localparam int SHIFT_W = 5;
  localparam int IFM_W   = LANES * DATA_W;
  localparam int W_W     = NUM_PE * LANES * DATA_W;

  logic clk = 1'b0;
  logic reset_n;
  int   n_checks = 0;
  int   n_errors = 0;
  logic [W_W-1:0] wv;
  logic seen_valid;

  hex_pe_cluster_array_if #(
    .NUM_PE(NUM_PE), .LANES(LANES), .DATA_W(DATA_W), .SHIFT_W(SHIFT_W)
  ) bus ();

  hex_pe_cluster_array #(
    .NUM_PE(NUM_PE), .LANES(LANES), .DATA_W(DATA_W), .ACC_W(ACC_W), .SHIFT_W(SHIFT_W)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [IFM_W-1:0] rep_ifm(input logic [7:0] v);
    logic [IFM_W-1:0] r;
    for (int i = 0; i < LANES; i++) r[i*DATA_W +: DATA_W] = v;
    return r;
  endfunction

  function automatic logic [W_W-1:0] rep_w(input logic [7:0] v0, input logic [7:0] v1,
                                           input logic [7:0] v2, input logic [7:0] v3);
    logic [W_W-1:0] r;
    logic [7:0]     v [NUM_PE];
    v[0] = v0; v[1] = v1; v[2] = v2; v[3] = v3;
    for (int p = 0; p < NUM_PE; p++)
      for (int i = 0; i < LANES; i++) r[(p*LANES+i)*DATA_W +: DATA_W] = v[p];
    return r;
  endfunction

  // Present one beat, wait (bounded) for in_ready, let it be accepted.
  task automatic send_beat(input logic [IFM_W-1:0] i_v, input logic [W_W-1:0] w_v,
                           input logic last, input logic [NUM_PE-1:0] en,
                           input logic [SHIFT_W-1:0] sh, input logic relu);
    int k = 0;
    bus.ifm = i_v; bus.weight = w_v; bus.in_last = last;
    bus.pe_enable = en; bus.shift = sh; bus.relu_en = relu;
    bus.in_valid = 1'b1;
    while (bus.in_ready !== 1'b1 && k < 20) begin
      @(posedge clk); #1; k++;
    end
    check("in_ready_at_beat", bus.in_ready, 1'b1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  // Called one cycle after the last beat was accepted; result expected 3 cycles after it.
  task automatic expect_result(input string tag, input logic [31:0] e_ofm,
                               input logic [3:0] e_mask);
    int k = 1;
    while (bus.ofm_valid !== 1'b1 && k < 20) begin
      @(posedge clk); #1; k++;
    end
    check({tag, "_lat"}, k, 3);
    check({tag, "_ofm"}, bus.ofm, e_ofm);
    check({tag, "_mask"}, bus.ofm_mask, e_mask);
  endtask

  // Consumer takes the result on the next edge.
  task automatic finish_output(input string tag);
    bus.ofm_ready = 1'b1;
    @(posedge clk); #1;
    check({tag, "_valid_drop"}, bus.ofm_valid, 1'b0);
    check({tag, "_ready_back"}, bus.in_ready, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n       = 1'b0;
    bus.ifm       = rep_ifm(8'd1);
    bus.weight    = rep_w(8'd1, 8'd1, 8'd1, 8'd1);
    bus.in_last   = 1'b1;
    bus.pe_enable = 4'b1111;
    bus.shift     = 5'd0;
    bus.relu_en   = 1'b0;
    bus.ofm_ready = 1'b1;
    bus.in_valid  = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", bus.busy, 1'b0);
    check("rst_ofm_valid", bus.ofm_valid, 1'b0);
    check("rst_ofm", bus.ofm, 32'h0);
    check("rst_mask", bus.ofm_mask, 4'h0);
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    reset_n      = 1'b1;
    @(posedge clk); #1;
    check("post_rst_ready", bus.in_ready, 1'b1);
    check("post_rst_busy", bus.busy, 1'b0);

    // Single beat of all ones: 16 per engine.
    send_beat(rep_ifm(8'd1), rep_w(8'd1, 8'd1, 8'd1, 8'd1), 1'b1, 4'b1111, 5'd0, 1'b0);
    expect_result("ones", 32'h10101010, 4'b1111);
    check("ones_busy", bus.busy, 1'b1);
    finish_output("ones");

    // Three beats of 127*127*16, shift 13: (774192 + 4096) >> 13 = 95.
    send_beat(rep_ifm(8'd127), rep_w(8'd127, 8'd0, 8'd0, 8'd0), 1'b0, 4'b1111, 5'd13, 1'b0);
    send_beat(rep_ifm(8'd127), rep_w(8'd127, 8'd0, 8'd0, 8'd0), 1'b0, 4'b1111, 5'd13, 1'b0);
    send_beat(rep_ifm(8'd127), rep_w(8'd127, 8'd0, 8'd0, 8'd0), 1'b1, 4'b1111, 5'd13, 1'b0);
    expect_result("round", 32'h0000005F, 4'b1111);
    finish_output("round");

    // -128*127 on one lane of PE1, shift 4: -1016 clamps to -128; ReLU gives 0.
    wv = '0;
    wv[(1*LANES)*DATA_W +: DATA_W] = 8'd127;
    send_beat(rep_ifm(8'h80), wv, 1'b1, 4'b1111, 5'd4, 1'b0);
    expect_result("clamp", 32'h00008000, 4'b1111);
    finish_output("clamp");
    send_beat(rep_ifm(8'h80), wv, 1'b1, 4'b1111, 5'd4, 1'b1);
    expect_result("relu", 32'h00000000, 4'b1111);
    finish_output("relu");

    // Mask 0101 latched; later-beat mask/shift/relu ignored: 32,0,96,0.
    send_beat(rep_ifm(8'd1), rep_w(8'd1, 8'd2, 8'd3, 8'd4), 1'b0, 4'b0101, 5'd0, 1'b0);
    send_beat(rep_ifm(8'd1), rep_w(8'd1, 8'd2, 8'd3, 8'd4), 1'b1, 4'b1111, 5'd1, 1'b1);
    expect_result("mask", 32'h00600020, 4'b0101);
    finish_output("mask");

    // All engines disabled: result still produced, all zero.
    send_beat(rep_ifm(8'd1), rep_w(8'd1, 8'd1, 8'd1, 8'd1), 1'b1, 4'b0000, 5'd0, 1'b0);
    expect_result("nomask", 32'h00000000, 4'b0000);
    finish_output("nomask");

    // Backpressure: result held 5 cycles, then next window starts in d+1.
    bus.ofm_ready = 1'b0;
    send_beat(rep_ifm(8'd1), rep_w(8'd1, 8'd1, 8'd1, 8'd1), 1'b1, 4'b1111, 5'd0, 1'b0);
    expect_result("stall", 32'h10101010, 4'b1111);
    for (int j = 0; j < 5; j++) begin
      @(posedge clk); #1;
      check("stall_hold_ofm", bus.ofm, 32'h10101010);
      check("stall_hold_valid", bus.ofm_valid, 1'b1);
      check("stall_in_ready", bus.in_ready, 1'b0);
    end
    finish_output("stall");
    send_beat(rep_ifm(8'd2), rep_w(8'd3, 8'd3, 8'd3, 8'd3), 1'b1, 4'b1111, 5'd0, 1'b0);
    expect_result("after_stall", 32'h60606060, 4'b1111);
    finish_output("after_stall");

    // Reset after 2 beats of a 4-beat window discards it.
    send_beat(rep_ifm(8'd5), rep_w(8'd5, 8'd5, 8'd5, 8'd5), 1'b0, 4'b1111, 5'd0, 1'b0);
    send_beat(rep_ifm(8'd5), rep_w(8'd5, 8'd5, 8'd5, 8'd5), 1'b0, 4'b1111, 5'd0, 1'b0);
    reset_n = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    seen_valid = 1'b0;
    for (int j = 0; j < 6; j++) begin
      seen_valid = seen_valid | bus.ofm_valid;
      @(posedge clk); #1;
    end
    check("mid_rst_no_valid", seen_valid, 1'b0);
    check("mid_rst_busy", bus.busy, 1'b0);
    send_beat(rep_ifm(8'd1), rep_w(8'd1, 8'd1, 8'd1, 8'd1), 1'b1, 4'b1111, 5'd0, 1'b0);
    expect_result("post_rst", 32'h10101010, 4'b1111);
    finish_output("post_rst");

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
